alu_serial_sequencer: RTL and testbench

- Bit-serial controller and initiator for the 1-bit ALU slice interface. It takes a 32-bit operation request and drives one external slice one bit per cycle, LSB first.
- Each cycle it feeds src1/src2/less/A_invert/B_invert/cin/operation to the slice and captures the slice's result/cout.
- After the last bit it assembles the 32-bit result and the zero, cout and overflow flags.
- Used as the area-minimal ALU variant in the datapath, beside the ripple 32-bit ALU.

---
 rtl/alu_serial_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_serial_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: drives one external 1-bit ALU slice LSB first and
// assembles the WIDTH-bit result plus zero/carry/overflow flags.
//
// state | meaning
// IDLE  | waiting for start_i, slice inputs driven 0
// RUN   | one operand bit per cycle through the slice
// DONE  | one-cycle done_o pulse, result and flags valid
module alu_serial_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ALU_control_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             slice_src1_o,
  output logic             slice_src2_o,
  output logic             slice_less_o,
  output logic             slice_A_invert_o,
  output logic             slice_B_invert_o,
  output logic             slice_cin_o,
  output logic [1:0]       slice_operation_o,
  input  logic             slice_result_i,
  input  logic             slice_cout_i
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-2:0] acc;
  logic [3:0]       ctrl_reg;
  logic [IDX_W-1:0] idx;
  logic             carry;

  // {legal, arith, A_invert, B_invert, slice op}
  function automatic logic [5:0] decode(input logic [3:0] code);
    case (code)
      4'b0000: decode = 6'b10_00_00;
      4'b0001: decode = 6'b10_00_01;
      4'b0010: decode = 6'b11_00_10;
      4'b0110: decode = 6'b11_01_10;
      4'b0111: decode = 6'b11_01_10;
      4'b1100: decode = 6'b10_11_00;
      default: decode = 6'b00_00_00;
    endcase
  endfunction

  logic [5:0] dec_run;
  logic       req_b_inv;
  logic       is_slt;
  assign dec_run   = decode(ctrl_reg);
  assign is_slt    = (ctrl_reg == 4'b0111);
  assign req_b_inv = (ALU_control_i == 4'b0110) || (ALU_control_i == 4'b0111) ||
                     (ALU_control_i == 4'b1100);

  // Final-bit view: the MSB comes straight from the slice on the last RUN edge.
  logic [WIDTH-1:0] sum_final;
  logic             ovf_final;
  logic [WIDTH-1:0] result_final;
  assign sum_final = {slice_result_i, acc};
  assign ovf_final = carry ^ slice_cout_i;

  always_comb begin
    result_final = '0;
    if (dec_run[5]) begin
      if (is_slt) result_final = {{(WIDTH-1){1'b0}}, sum_final[WIDTH-1] ^ ovf_final};
      else        result_final = sum_final;
    end
  end

  assign slice_less_o = 1'b0;

  always_comb begin
    slice_src1_o      = 1'b0;
    slice_src2_o      = 1'b0;
    slice_cin_o       = 1'b0;
    slice_A_invert_o  = 1'b0;
    slice_B_invert_o  = 1'b0;
    slice_operation_o = 2'b00;
    if (state == S_RUN) begin
      slice_src1_o      = a_reg[idx];
      slice_src2_o      = b_reg[idx];
      slice_cin_o       = carry;
      slice_A_invert_o  = dec_run[3];
      slice_B_invert_o  = dec_run[2];
      slice_operation_o = dec_run[1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      ctrl_reg   <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            a_reg    <= src1_i;
            b_reg    <= src2_i;
            ctrl_reg <= ALU_control_i;
            idx      <= '0;
            carry    <= req_b_inv;
            busy_o   <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= {slice_result_i, acc[WIDTH-2:1]};
          carry <= slice_cout_i;
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            result_o   <= result_final;
            zero_o     <= (result_final == '0);
            cout_o     <= dec_run[4] & slice_cout_i;
            overflow_o <= dec_run[4] & ovf_final;
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            state      <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer with a behavioural 1-bit ALU slice.
module tb_alu_serial_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src1, src2;
  logic [3:0]  alu_ctrl;
  logic        busy_o, done_o, zero_o, cout_o, overflow_o;
  logic [31:0] result_o;
  logic        slice_src1_o, slice_src2_o, slice_less_o;
  logic        slice_A_invert_o, slice_B_invert_o, slice_cin_o;
  logic [1:0]  slice_operation_o;
  logic        slice_result, slice_cout;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_res = 32'h0;

  always #5 clk = ~clk;

  alu_serial_sequencer #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .src1_i(src1), .src2_i(src2), .ALU_control_i(alu_ctrl),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .zero_o(zero_o), .cout_o(cout_o), .overflow_o(overflow_o),
    .slice_src1_o(slice_src1_o), .slice_src2_o(slice_src2_o),
    .slice_less_o(slice_less_o), .slice_A_invert_o(slice_A_invert_o),
    .slice_B_invert_o(slice_B_invert_o), .slice_cin_o(slice_cin_o),
    .slice_operation_o(slice_operation_o),
    .slice_result_i(slice_result), .slice_cout_i(slice_cout)
  );

  // Behavioural 1-bit ALU slice
  logic sa, sb;
  always_comb begin
    sa = slice_src1_o ^ slice_A_invert_o;
    sb = slice_src2_o ^ slice_B_invert_o;
    case (slice_operation_o)
      2'b00:   slice_result = sa & sb;
      2'b01:   slice_result = sa | sb;
      2'b10:   slice_result = sa ^ sb ^ slice_cin_o;
      default: slice_result = slice_less_o;
    endcase
    slice_cout = (sa & sb) | (sa & slice_cin_o) | (sb & slice_cin_o);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] code,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_z,
                       input logic exp_c, input logic exp_v,
                       input logic exp_ai, input logic exp_bi, input logic [1:0] exp_op);
    int edges;
    @(negedge clk);
    alu_ctrl = code; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    while (!done_o && edges < 60) begin
      if (busy_o) begin
        check_eq({tag, ".ainv"}, {31'b0, slice_A_invert_o}, {31'b0, exp_ai});
        check_eq({tag, ".binv"}, {31'b0, slice_B_invert_o}, {31'b0, exp_bi});
        check_eq({tag, ".sop"},  {30'b0, slice_operation_o}, {30'b0, exp_op});
        check_eq({tag, ".sa"},   {31'b0, slice_src1_o}, {31'b0, a[edges-1]});
        check_eq({tag, ".sb"},   {31'b0, slice_src2_o}, {31'b0, b[edges-1]});
      end
      if (edges == 17) check_eq({tag, ".res_hold_run"}, result_o, last_res);
      @(posedge clk); #1;
      edges++;
    end
    check_eq({tag, ".latency"}, 32'(edges), 32'd33);
    check_eq({tag, ".res"},  result_o, exp_res);
    check_eq({tag, ".zero"}, {31'b0, zero_o}, {31'b0, exp_z});
    check_eq({tag, ".cout"}, {31'b0, cout_o}, {31'b0, exp_c});
    check_eq({tag, ".ovf"},  {31'b0, overflow_o}, {31'b0, exp_v});
    check_eq({tag, ".busy_done"}, {31'b0, busy_o}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, ".done_pulse"}, {31'b0, done_o}, 32'd0);
    check_eq({tag, ".res_hold"}, result_o, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    int          ndone;
    logic [31:0] res_at_done;
    logic [31:0] a_sec, b_sec;
    int          edges;

    rst = 1'b1; start = 1'b0; src1 = '0; src2 = '0; alu_ctrl = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.busy",   {31'b0, busy_o}, 32'd0);
    check_eq("rst.done",   {31'b0, done_o}, 32'd0);
    check_eq("rst.res",    result_o, 32'd0);
    check_eq("rst.zero",   {31'b0, zero_o}, 32'd0);
    check_eq("rst.flags",  {30'b0, cout_o, overflow_o}, 32'd0);
    check_eq("rst.slice",  {25'b0, slice_src1_o, slice_src2_o, slice_less_o, slice_A_invert_o,
                            slice_B_invert_o, slice_cin_o, |slice_operation_o}, 32'd0);
    @(negedge clk); rst = 1'b0;

    do_op("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0, 0, 2'b10);
    do_op("sub_eq",   4'b0110, 32'd5, 32'd5, 32'h0, 1, 1, 0, 0, 1, 2'b10);
    do_op("sub_neg",  4'b0110, 32'd0, 32'd1, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 2'b10);
    do_op("slt_neg",  4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h1, 0, 1, 0, 0, 1, 2'b10);
    do_op("slt_ovf",  4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h0, 1, 0, 1, 0, 1, 2'b10);
    do_op("slt_eq",   4'b0111, 32'd3, 32'd3, 32'h0, 1, 1, 0, 0, 1, 2'b10);
    do_op("nor",      4'b1100, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 0, 0, 0, 1, 1, 2'b00);
    do_op("and",      4'b0000, 32'h0F0F0F0F, 32'h00FF00FF, 32'h000F000F, 0, 0, 0, 0, 0, 2'b00);
    do_op("or",       4'b0001, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FFF0FFF, 0, 0, 0, 0, 0, 2'b01);
    do_op("illegal",  4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1, 0, 0, 0, 0, 2'b00);
    do_op("or_again", 4'b0001, 32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 0, 0, 0, 2'b01);

    // asynchronous reset in the middle of bit 17 of an ADD
    @(negedge clk);
    alu_ctrl = 4'b0010; src1 = 32'hFFFFFFFF; src2 = 32'h1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    check_eq("mid.cin_before", {31'b0, slice_cin_o}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid.busy", {31'b0, busy_o}, 32'd0);
    check_eq("mid.res",  result_o, 32'd0);
    check_eq("mid.zero", {31'b0, zero_o}, 32'd0);
    check_eq("mid.slice", {29'b0, slice_src1_o, slice_src2_o, slice_cin_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_o) ndone++;
    end
    check_eq("mid.no_done", 32'(ndone), 32'd0);
    last_res = 32'h0;
    do_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 0, 2'b10);

    // start held high for 40 cycles with changing operands
    @(negedge clk);
    alu_ctrl = 4'b0010; src1 = 32'd10; src2 = 32'd20; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; res_at_done = '0; a_sec = '0; b_sec = '0;
    for (int e = 2; e <= 40; e++) begin
      @(negedge clk);
      src1 = $urandom; src2 = $urandom;
      if (e == 35) begin a_sec = src1; b_sec = src2; end
      @(posedge clk); #1;
      if (done_o) begin ndone++; res_at_done = result_o; end
      if (e == 34) check_eq("hold.idle_gap", {31'b0, busy_o}, 32'd0);
      if (e == 35) check_eq("hold.reaccept", {31'b0, busy_o}, 32'd1);
    end
    start = 1'b0;
    check_eq("hold.one_done", 32'(ndone), 32'd1);
    check_eq("hold.res", res_at_done, 32'd30);
    edges = 0;
    while (!done_o && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
    check_eq("hold.second_done", {31'b0, done_o}, 32'd1);
    check_eq("hold.second_res", result_o, a_sec + b_sec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
